// File: rtl/user_id_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : user_id_pkg
//  Description : Shared definitions for the project-ID serializer: FSM state
//                encoding, frame geometry, divider bounds and the parity
//                helper used when the ID snapshot is taken.
//  Revision    : 1.0  initial release
// ============================================================================
package user_id_pkg;

   // Serializer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Frame geometry: 32 ID bits followed by one even-parity bit
   localparam int c_id_width   = 32;
   localparam int c_frame_len  = 33;

   // Legal range of the sclk half-period (in clock cycles)
   localparam int c_div_min    = 1;
   localparam int c_div_max    = 255;

   // Counter widths
   localparam int c_bit_cnt_w  = 6;
   localparam int c_half_cnt_w = 8;

   // XOR reduction of the ID; transmitted as the last bit of the frame
   function automatic logic id_parity(input logic [c_id_width-1:0] id);
      return ^id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/user_id_clkdiv.sv
`default_nettype none
// ============================================================================
//  Module      : user_id_clkdiv
//  Description : Half-period counter for the serial clock. While enabled it
//                holds sclk low for DIV cycles, then high for DIV cycles, and
//                strobes o_bit_end on the final cycle of the high half so the
//                parent can advance to the next bit.
//  Ports       : clk        - clock
//                rst_n      - asynchronous active-low reset
//                i_en       - count (parent is shifting)
//                i_clr      - synchronous clear back to the start of a bit
//                o_sclk     - registered serial clock, idle low
//                o_bit_end  - last cycle of the current bit (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module user_id_clkdiv
   import user_id_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_sclk,
   output logic o_bit_end
);

   localparam logic [c_half_cnt_w-1:0] c_half_last = c_half_cnt_w'(DIV - 1);

   logic [c_half_cnt_w-1:0] r_half_cnt;
   logic                    r_phase;     // 0 = low half, 1 = high half
   logic                    w_half_end;

   assign w_half_end = (r_half_cnt == c_half_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half_cnt <= '0;
         r_phase    <= 1'b0;
      end else if (i_clr) begin
         r_half_cnt <= '0;
         r_phase    <= 1'b0;
      end else if (i_en) begin
         if (w_half_end) begin
            r_half_cnt <= '0;
            r_phase    <= ~r_phase;
         end else begin
            r_half_cnt <= r_half_cnt + 8'd1;
         end
      end
   end

   // The phase flop is the serial clock itself, so sclk is glitch-free
   assign o_sclk    = r_phase;
   assign o_bit_end = i_en & w_half_end & r_phase;

endmodule
`default_nettype wire

// File: rtl/user_id_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : user_id_serializer
//  Description : On request, snapshots the 32-bit project ID and shifts it out
//                MSB-first on a csb/sclk/sdo serial link, followed by an
//                even-parity bit (33-bit frame). Every output is a flop.
//  Ports       : wb_clk_i  - clock
//                wb_rstn_i - asynchronous active-low reset
//                mask_rev  - project ID (quasi-static)
//                start     - request a readout (sampled in IDLE only)
//                abort     - cancel a readout in LOAD/SHIFT
//                busy      - high from LOAD through DONE
//                done      - one-cycle completion pulse
//                id_q      - ID snapshot taken at LOAD
//                id_valid  - id_q holds a completed, un-aborted snapshot
//                csb       - frame select, active-low
//                sclk      - serial clock, idle low
//                sdo       - serial data
//  Revision    : 1.0  initial release
// ============================================================================
module user_id_serializer
   import user_id_pkg::*;
#(
   parameter int DIV = 2,
   parameter int IDW = 32
) (
   input  logic           wb_clk_i,
   input  logic           wb_rstn_i,
   input  logic [IDW-1:0] mask_rev,
   input  logic           start,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   output logic [IDW-1:0] id_q,
   output logic           id_valid,
   output logic           csb,
   output logic           sclk,
   output logic           sdo
);

   generate
      if (DIV < c_div_min || DIV > c_div_max) begin : g_div_range_check
         $error("user_id_serializer: DIV outside 1..255");
      end
      if (IDW != c_id_width) begin : g_idw_check
         $error("user_id_serializer: IDW must be 32");
      end
   endgenerate

   localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(c_frame_len - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [c_bit_cnt_w-1:0] r_bit_cnt;
   logic [IDW:0]           r_shift;      // {ID, parity}; MSB drives sdo
   logic [IDW-1:0]         r_id_q;
   logic                   r_id_valid;
   logic                   r_csb;
   logic                   r_busy;
   logic                   r_done;
   logic                   w_csb_nxt;
   logic                   w_busy_nxt;
   logic                   w_done_nxt;
   logic                   w_bit_end;
   logic                   w_last_bit;
   logic                   w_div_en;
   logic                   w_div_clr;

   assign w_last_bit = (r_bit_cnt == c_last_bit);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and next values of the registered control outputs.
   // Outputs are derived from the next state so they line up with it.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            // abort has no meaning in IDLE, so start always wins here
            if (start) begin
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_next_state = abort ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (w_bit_end && w_last_bit) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            // abort is ignored: the frame has already been delivered
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      w_csb_nxt  = (w_next_state != ST_SHIFT);
      w_busy_nxt = (w_next_state != ST_IDLE);
      w_done_nxt = (w_next_state == ST_DONE);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_csb  <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_csb  <= w_csb_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Serial clock generation. The divider only runs in SHIFT and is cleared
   // on any exit from SHIFT, so every frame and every abort leaves sclk low.
   // ------------------------------------------------------------------------
   assign w_div_en  = (r_state == ST_SHIFT);
   assign w_div_clr = (w_next_state != ST_SHIFT);

   user_id_clkdiv #(
      .DIV (DIV)
   ) u_clkdiv (
      .clk       (wb_clk_i),
      .rst_n     (wb_rstn_i),
      .i_en      (w_div_en),
      .i_clr     (w_div_clr),
      .o_sclk    (sclk),
      .o_bit_end (w_bit_end)
   );

   // ------------------------------------------------------------------------
   // Snapshot, shift register and bit counter
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_id_q     <= '0;
         r_id_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_id_q     <= mask_rev;
               r_id_valid <= 1'b0;
               r_bit_cnt  <= '0;
               // An abort here must leave sdo low in the following IDLE
               if (abort) begin
                  r_shift <= '0;
               end else begin
                  r_shift <= {mask_rev, id_parity(mask_rev)};
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  r_shift   <= '0;
                  r_bit_cnt <= '0;
               end else if (w_bit_end) begin
                  // Zeros shift in behind, so sdo falls to 0 after the parity bit
                  r_shift <= {r_shift[IDW-1:0], 1'b0};
                  if (w_last_bit) begin
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
               end
            end
            ST_DONE: begin
               r_id_valid <= 1'b1;
            end
            default: begin
               r_shift   <= '0;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign id_q     = r_id_q;
   assign id_valid = r_id_valid;
   assign csb      = r_csb;
   assign sdo      = r_shift[IDW];

endmodule
`default_nettype wire

// File: tb/tb_user_id_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_id_serializer
//  Description : Directed self-checking bench for user_id_serializer. Two
//                instances (DIV=2 and DIV=1) share all inputs; one is
//                selected for observation per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_user_id_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mask_rev;
   logic        start;
   logic        abort;

   logic        busy_a, done_a, idv_a, csb_a, sclk_a, sdo_a;
   logic [31:0] idq_a;
   logic        busy_b, done_b, idv_b, csb_b, sclk_b, sdo_b;
   logic [31:0] idq_b;

   int          sel;
   logic        m_busy, m_done, m_idv, m_csb, m_sclk, m_sdo;
   logic [31:0] m_idq;

   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   user_id_serializer #(.DIV(2), .IDW(32)) u_dut_a (
      .wb_clk_i (clk),    .wb_rstn_i (rst_n), .mask_rev (mask_rev),
      .start    (start),  .abort     (abort), .busy     (busy_a),
      .done     (done_a), .id_q      (idq_a), .id_valid (idv_a),
      .csb      (csb_a),  .sclk      (sclk_a), .sdo     (sdo_a)
   );

   user_id_serializer #(.DIV(1), .IDW(32)) u_dut_b (
      .wb_clk_i (clk),    .wb_rstn_i (rst_n), .mask_rev (mask_rev),
      .start    (start),  .abort     (abort), .busy     (busy_b),
      .done     (done_b), .id_q      (idq_b), .id_valid (idv_b),
      .csb      (csb_b),  .sclk      (sclk_b), .sdo     (sdo_b)
   );

   always_comb begin
      if (sel == 1) begin
         m_busy = busy_b; m_done = done_b; m_idv = idv_b; m_csb = csb_b;
         m_sclk = sclk_b; m_sdo  = sdo_b;  m_idq = idq_b;
      end else begin
         m_busy = busy_a; m_done = done_a; m_idv = idv_a; m_csb = csb_a;
         m_sclk = sclk_a; m_sdo  = sdo_a;  m_idq = idq_a;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((busy_a || busy_b) && k < 400) begin
         tick();
         k++;
      end
      chk({tag, "_idle"}, {62'd0, busy_a, busy_b}, 64'd0);
   endtask

   // One frame on the selected instance; expected values come from the caller
   task automatic run_frame(input string tag, input logic [31:0] val, input logic par,
                            input int which, input int exp_done,
                            input bit swap_mid, input bit abort_in_done);
      logic [32:0] bits;
      int          nbits, csb_bad, n, done_at;
      logic        prev;
      sel      = which;
      mask_rev = val;
      start    = 1'b1;
      bits     = '0;
      nbits    = 0;
      csb_bad  = 0;
      n        = 0;
      done_at  = -1;
      prev     = 1'b0;
      while (done_at < 0 && n < exp_done + 20) begin
         tick();
         n++;
         start = 1'b0;
         if (swap_mid && n == 20) mask_rev = 32'hFFFF_FFFF;
         if (m_sclk && !prev) begin
            bits = {bits[31:0], m_sdo};
            nbits++;
            if (m_csb) csb_bad++;
         end
         prev = m_sclk;
         if (m_done) begin
            done_at = n;
            if (abort_in_done) abort = 1'b1;
         end
      end
      chk({tag, "_done_cycle"}, done_at, exp_done);
      chk({tag, "_frame"}, {31'd0, bits}, {31'd0, val, par});
      chk({tag, "_sclk_pulses"}, nbits, 33);
      chk({tag, "_csb_low"}, csb_bad, 0);
      chk({tag, "_id_q"}, m_idq, val);
      tick();
      abort = 1'b0;
      chk({tag, "_post"}, {60'd0, m_done, m_busy, m_idv, m_csb}, 64'h3);
   endtask

   task automatic abort_bit10();
      int   nbits, n, seen;
      logic prev;
      sel      = 2;
      mask_rev = 32'hFFFF_0000;
      start    = 1'b1;
      nbits    = 0;
      n        = 0;
      prev     = 1'b0;
      while (nbits < 10 && n < 200) begin
         tick();
         n++;
         start = 1'b0;
         if (m_sclk && !prev) nbits++;
         prev = m_sclk;
      end
      chk("abort_reach_bit10", nbits, 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outputs", {60'd0, m_csb, m_sclk, m_sdo, m_busy}, 64'h8);
      seen = 0;
      repeat (150) begin
         tick();
         if (m_done) seen++;
      end
      chk("abort_no_done", seen, 0);
      chk("abort_id_valid", m_idv, 0);
   endtask

   task automatic start_held();
      int first, second, cnt, gap;
      sel      = 2;
      mask_rev = 32'h1357_9BDF;
      start    = 1'b1;
      first    = -1;
      second   = -1;
      cnt      = 0;
      gap      = 0;
      for (int n = 1; n <= 320; n++) begin
         tick();
         if (n == 200) start = 1'b0;
         if (m_done) begin
            cnt++;
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
         if (!m_busy && n > 1 && n < 269) gap++;
      end
      chk("held_first_done", first, 134);
      chk("held_second_done", second, 269);
      chk("held_done_count", cnt, 2);
      chk("held_idle_gap", gap, 1);
   endtask

   task automatic abort_with_start();
      sel      = 2;
      mask_rev = 32'h0F0F_0F0F;
      start    = 1'b1;
      abort    = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_load_busy", m_busy, 1);
      tick();
      chk("abort_start_shift_csb", m_csb, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic reset_mid_shift();
      int seen;
      sel      = 2;
      mask_rev = 32'hA5A5_1234;
      start    = 1'b1;
      repeat (50) begin
         tick();
         start = 1'b0;
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", {58'd0, m_csb, m_sclk, m_sdo, m_busy, m_done, m_idv}, 64'h20);
      chk("rst_mid_id_q", m_idq, 0);
      #2;
      rst_n = 1'b1;
      seen = 0;
      repeat (150) begin
         tick();
         if (m_done) seen++;
      end
      chk("rst_mid_no_done", seen, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      mask_rev = 32'h0;
      sel      = 2;
      repeat (3) tick();
      chk("reset_csb",      csb_a,  1);
      chk("reset_sclk_sdo", {sclk_a, sdo_a}, 0);
      chk("reset_busy",     busy_a, 0);
      chk("reset_done",     done_a, 0);
      chk("reset_id_valid", idv_a,  0);
      chk("reset_id_q",     idq_a,  0);
      rst_n = 1'b1;
      tick();

      run_frame("a5a51234", 32'hA5A5_1234, 1'b1, 2, 134, 1'b0, 1'b0);
      wait_idle("a5a51234");
      run_frame("zero_div1", 32'h0000_0000, 1'b0, 1, 68, 1'b0, 1'b0);
      wait_idle("zero_div1");
      run_frame("snapshot", 32'h0000_0001, 1'b1, 2, 134, 1'b1, 1'b1);
      wait_idle("snapshot");
      abort_bit10();
      run_frame("after_abort", 32'hFFFF_0000, 1'b0, 2, 134, 1'b0, 1'b0);
      wait_idle("after_abort");
      start_held();
      wait_idle("held");
      abort_with_start();
      wait_idle("abort_start");
      reset_mid_shift();
      run_frame("after_reset", 32'hA5A5_1234, 1'b1, 2, 134, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/user_id_serializer.md
USER_ID_SERIALIZER -- requirements
Module: user_id_serializer

Interface
REQ-001 Parameter DIV, default 2, meaning: half-period of sclk in wb_clk_i cycles; legal range 1..255.
REQ-002 Parameter IDW, default 32, meaning: width of the project ID consumed; fixed at 32 in this release.
REQ-003 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 mask_rev  input  32  project ID from the constant-cell ID block; quasi-static.
REQ-006 start  input  1  request a readout; sampled only in IDLE.
REQ-007 abort  input  1  cancel a readout in progress.
REQ-008 busy  output  1  high from LOAD through DONE inclusive.
REQ-009 done  output  1  single-cycle pulse on completion of a frame.
REQ-010 id_q  output  32  snapshot of mask_rev taken at LOAD.
REQ-011 id_valid  output  1  id_q holds a completed, un-aborted snapshot.
REQ-012 csb  output  1  frame select, active-low.
REQ-013 sclk  output  1  serial clock, idle low.
REQ-014 sdo  output  1  serial data.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE: csb=1, sclk=0, sdo=0, busy=0; start=1 -> LOAD next cycle.
REQ-017 LOAD (1 cycle): shift register <= mask_rev; id_q <= mask_rev; parity bit <= XOR of all 32 mask_rev bits; id_valid <= 0; -> SHIFT.
REQ-018 SHIFT: csb=0; frame is 33 bits: mask_rev[31] first down to [0], then parity bit.
REQ-019 Each bit SHALL occupy 2*DIV cycles: sclk low for DIV cycles, then high for DIV cycles; sdo changes only at the start of the low half.
REQ-020 Bit counter SHALL be 6 bits and half-period counter 8 bits; counters SHALL NOT wrap inside a frame.
REQ-021 After the high half of bit 33: -> DONE; DONE (1 cycle): done=1, id_valid<=1, csb=1, sclk=0; -> IDLE.
REQ-022 done SHALL assert exactly 2+66*DIV cycles after the cycle in which start is sampled.
REQ-023 start while busy SHALL be ignored (no queueing).
REQ-024 abort=1 in LOAD or SHIFT: next cycle IDLE, csb=1, sclk=0, sdo=0, no done, id_valid=0.
REQ-025 abort and start in the same IDLE cycle: abort has no effect; LOAD entered.
REQ-026 abort in DONE: ignored; done pulse and id_valid<=1 still occur.
REQ-027 Changes on mask_rev after LOAD SHALL not affect the frame or id_q.
REQ-028 All outputs SHALL be registered (no combinational path from inputs).

Reset
REQ-029 wb_rstn_i low SHALL immediately force IDLE, csb=1, sclk=0, sdo=0, busy=0, done=0, id_valid=0, id_q=0, counters=0.
REQ-030 Reset mid-frame SHALL terminate the frame without a done pulse; first start after deassertion behaves as from power-up.

Structure
REQ-031 FSM state encodings, frame length (33) and DIV legal bounds SHALL live in a shared package user_id_pkg.
REQ-032 One sub-module, user_id_clkdiv (half-period counter producing sclk and bit-advance strobe), SHALL be used; parity and shift logic stay in the top.

Verification
REQ-033 mask_rev=32'hA5A5_1234, DIV=2, start pulse -> sdo sequence A5A51234 MSB-first then parity 1; done at cycle 134; id_q=32'hA5A5_1234, id_valid=1.
REQ-034 mask_rev=32'h0000_0000, DIV=1 -> 33 zero bits, parity 0, 33 sclk pulses, done at cycle 68.
REQ-035 start held high for 200 cycles, DIV=2 -> exactly one frame per 135-cycle IDLE-to-IDLE loop, no overlap, csb high for one IDLE cycle between frames.
REQ-036 abort asserted at bit 10 of a frame -> csb=1 next cycle, no done, id_valid=0; new start yields full correct frame.
REQ-037 wb_rstn_i pulsed low mid-SHIFT (asynchronously, off clock edge) -> outputs at reset values before the next rising edge; no done.
REQ-038 mask_rev changed to 32'hFFFF_FFFF during SHIFT of 32'h0000_0001 -> serial frame and id_q reflect 32'h0000_0001, parity 1.
